multiplier_nbits_seq: RTL

Parametrised sequential shift-add multiplier. It is the successor to the fixed 8-bit start/ready multiplier.
- Generalised to WIDTH-bit operands.
- Adds a per-operation signed (two's complement) mode, a zero-operand early exit and an explicit BUSY flag.
- Sits in the datapath as a multi-cycle arithmetic unit driven by a controller using the S/PRONTO handshake.

---
 rtl/multiplier_nbits_seq_if.sv | 23 ++
 rtl/multiplier_nbits_seq.sv | 106 ++++++++++
 2 files changed

// File: rtl/multiplier_nbits_seq_if.sv
// multiplier_nbits_seq_if: operand/start and result/status bundle
// between a datapath controller and the shift-add multiplier.
interface multiplier_nbits_seq_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   w;
  logic [WIDTH-1:0]   y;
  logic               SGN;
  logic               S;
  logic [2*WIDTH-1:0] result;
  logic               PRONTO;
  logic               BUSY;

  modport master (
    output w, y, SGN, S,
    input  result, PRONTO, BUSY
  );

  modport slave (
    input  w, y, SGN, S,
    output result, PRONTO, BUSY
  );
endinterface

// File: rtl/multiplier_nbits_seq.sv
// multiplier_nbits_seq: WIDTH-bit sequential shift-add multiplier
// with signed mode, zero early exit and S/PRONTO/BUSY handshake.
module multiplier_nbits_seq #(
  parameter int WIDTH = 8
) (
  input logic             CLK,
  input logic             RESET,
  multiplier_nbits_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN
  } state_t;

  state_t state, state_n;

  logic [2*WIDTH:0]   acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] result_q;
  logic               pronto_q;
  logic               busy_q;

  logic [WIDTH-1:0]   mag_w;
  logic [WIDTH-1:0]   mag_y;
  logic [WIDTH:0]     sum;
  logic               zero;
  logic               neg_in;
  logic               last;

  // Magnitudes stay unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
  always_comb begin
    mag_w  = bus.w;
    mag_y  = bus.y;
    if (bus.SGN && bus.w[WIDTH-1]) mag_w = -bus.w;
    if (bus.SGN && bus.y[WIDTH-1]) mag_y = -bus.y;
    neg_in = bus.SGN & (bus.w[WIDTH-1] ^ bus.y[WIDTH-1]);
    zero   = (mag_w == '0) || (mag_y == '0);
    sum    = acc[2*WIDTH:WIDTH]
           + (mplier[0] ? {1'b0, mcand} : '0);
    last   = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.S) state_n = zero ? SIGN : CALC;
      CALC:    if (last)  state_n = SIGN;
      SIGN:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      neg      <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
      pronto_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.S) begin
            mcand    <= mag_w;
            mplier   <= mag_y;
            neg      <= neg_in;
            acc      <= '0;
            cnt      <= '0;
            pronto_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        CALC: begin
          acc    <= {sum, acc[WIDTH-1:0]} >> 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        SIGN: begin
          result_q <= neg ? -acc[2*WIDTH-1:0]
                          :  acc[2*WIDTH-1:0];
          pronto_q <= 1'b1;
          busy_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.PRONTO = pronto_q;
  assign bus.BUSY   = busy_q;
endmodule
